// File: rtl/sram_row_ctrl.sv
// Word-line / precharge / bit-line sequencer for one SRAM row access per request.
// Optional write read-back verify enabled by defining SRAM_WVERIFY_EN.
module sram_row_ctrl #(
    parameter int unsigned AW      = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned PRE_CYC = 2,
    parameter int unsigned WL_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DW-1:0]     wdata,
    output logic              busy,
    output logic              ack,
    output logic [DW-1:0]     rdata,
    output logic              verr,
    output logic [2**AW-1:0]  wl,
    output logic              pre,
    output logic              drv_en,
    output logic [DW-1:0]     drv_d,
    output logic              sense_en,
    input  logic [DW-1:0]     sa_q
);

    localparam int unsigned NWL = 2**AW;
    localparam int unsigned CW  = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_DRV, S_PRE, S_WL, S_SENSE, S_REC, S_DONE
    } state_t;

    state_t          r_state, w_state_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic            r_we, w_we_nx;
    logic [AW-1:0]   r_addr, w_addr_nx;
    logic [DW-1:0]   r_wdata, w_wdata_nx;
    logic            r_vfy, w_vfy_nx;
    logic [NWL-1:0]  w_wl_nx;
    logic            w_drv_en_nx;

    // Next-state logic; the shared counter is reloaded on every PRE/WL entry.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_we_nx    = r_we;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        w_vfy_nx   = r_vfy;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_we_nx    = we;
                    w_addr_nx  = addr;
                    w_wdata_nx = wdata;
                    w_vfy_nx   = 1'b0;
                    if (we) begin
                        w_state_nx = S_DRV;
                    end else begin
                        w_state_nx = S_PRE;
                        w_cnt_nx   = CW'(PRE_CYC);
                    end
                end
            end
            S_DRV: begin
                w_state_nx = S_WL;
                w_cnt_nx   = CW'(WL_CYC);
            end
            S_PRE: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nx = S_WL;
                    w_cnt_nx   = CW'(WL_CYC);
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_WL: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nx = (r_we && !r_vfy) ? S_REC : S_SENSE;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_SENSE: w_state_nx = S_REC;
            S_REC: begin
`ifdef SRAM_WVERIFY_EN
                if (r_we && !r_vfy) begin
                    w_state_nx = S_PRE;
                    w_cnt_nx   = CW'(PRE_CYC);
                    w_vfy_nx   = 1'b1;
                end else begin
                    w_state_nx = S_DONE;
                end
`else
                w_state_nx = S_DONE;
`endif
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase

        // Array controls are decoded from the next state so they register in step with it.
        w_wl_nx = '0;
        if (w_state_nx == S_WL || w_state_nx == S_SENSE) begin
            w_wl_nx = NWL'(1) << w_addr_nx;
        end
        w_drv_en_nx = (w_state_nx == S_DRV) ||
                      (w_state_nx == S_WL && w_we_nx && !w_vfy_nx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_vfy    <= 1'b0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            rdata    <= '0;
            wl       <= '0;
            pre      <= 1'b0;
            drv_en   <= 1'b0;
            drv_d    <= '0;
            sense_en <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_we     <= w_we_nx;
            r_addr   <= w_addr_nx;
            r_wdata  <= w_wdata_nx;
            r_vfy    <= w_vfy_nx;
            busy     <= (w_state_nx != S_IDLE);
            ack      <= (w_state_nx == S_DONE);
            wl       <= w_wl_nx;
            pre      <= (w_state_nx == S_PRE);
            drv_en   <= w_drv_en_nx;
            drv_d    <= w_drv_en_nx ? w_wdata_nx : '0;
            sense_en <= (w_state_nx == S_SENSE);
            // Read-back during verify must not disturb the last read result.
            if (r_state == S_SENSE && !r_vfy) begin
                rdata <= sa_q;
            end
        end
    end

`ifdef SRAM_WVERIFY_EN
    logic r_vmis;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vmis <= 1'b0;
            verr   <= 1'b0;
        end else begin
            if (r_state == S_SENSE) begin
                r_vmis <= r_vfy && (sa_q != r_wdata);
            end
            verr <= (w_state_nx == S_DONE) && r_vfy && r_vmis;
        end
    end
`else
    assign verr = 1'b0;
`endif

endmodule

// File: tb/tb_sram_row_ctrl.sv
// Directed bench for sram_row_ctrl with a behavioural cell-array model on bl/sa_q.
module tb_sram_row_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [7:0]  wdata = '0;
    logic        busy, ack, verr, pre, drv_en, sense_en;
    logic [7:0]  rdata, drv_d, sa_q;
    logic [15:0] wl;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [16] = '{default: 8'h00};
    logic       force_ff = 1'b0;
    int         wl_idx;

`ifdef SRAM_WVERIFY_EN
    localparam int W_LAT = 11, W_PRE = 2, W_WL = 5, W_SENSE = 1;
`else
    localparam int W_LAT = 5,  W_PRE = 0, W_WL = 2, W_SENSE = 0;
`endif

    always #5 clk = ~clk;

    sram_row_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .verr(verr), .wl(wl), .pre(pre),
        .drv_en(drv_en), .drv_d(drv_d), .sense_en(sense_en), .sa_q(sa_q)
    );

    // Cell array: driven bit lines write the selected row; sense amp returns it.
    always_comb begin
        wl_idx = 0;
        for (int i = 0; i < 16; i++) if (wl[i]) wl_idx = i;
        sa_q = force_ff ? 8'hFF : mem[wl_idx];
    end

    always @(posedge clk) if (drv_en && (wl != 16'h0)) mem[wl_idx] <= drv_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inv_chk();
        chk("invariant", {31'd0, ($countones(wl) <= 1) && !(pre && ((wl != 16'h0) || drv_en))
                          && !(drv_en && sense_en)}, 32'd1);
    endtask

    int lat, n_pre, n_wl, n_wl_drv, n_sense, n_drv, verr_at_ack;
    logic [15:0] wl_seen;

    task automatic run_op(input logic i_we, input logic [3:0] i_addr, input logic [7:0] i_wd);
        @(negedge clk);
        req = 1'b1; we = i_we; addr = i_addr; wdata = i_wd;
        @(posedge clk);
        #1 req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        lat = 0; n_pre = 0; n_wl = 0; n_wl_drv = 0; n_sense = 0; n_drv = 0;
        verr_at_ack = 0; wl_seen = '0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            inv_chk();
            if (pre) n_pre++;
            if (wl != 16'h0) begin n_wl++; wl_seen = wl; if (drv_en) n_wl_drv++; end
            if (sense_en) n_sense++;
            if (drv_en && wl == 16'h0) n_drv++;
            if (ack) begin lat = c; verr_at_ack = int'(verr); end
        end
    endtask

    int acks, idles;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_verr", 32'(verr), 0);
        chk("rst_wl", 32'(wl), 0);
        chk("rst_ctl", {29'd0, pre, drv_en, sense_en}, 0);
        chk("rst_drv_d", 32'(drv_d), 0);
        rst = 1'b0;

        // Write addr 3 = 0x00
        run_op(1'b1, 4'd3, 8'h00);
        chk("w3_lat", 32'(lat), 32'(W_LAT));
        chk("w3_drv", 32'(n_drv), 1);
        chk("w3_wl", 32'(wl_seen), 32'h0008);
        chk("w3_wl_cyc", 32'(n_wl), 32'(W_WL));
        chk("w3_wl_drv", 32'(n_wl_drv), 2);
        chk("w3_pre", 32'(n_pre), 32'(W_PRE));
        chk("w3_sense", 32'(n_sense), 32'(W_SENSE));
        chk("w3_verr", 32'(verr_at_ack), 0);
        @(negedge clk);
        chk("w3_idle_busy", 32'(busy), 0);

        // Read addr 3
        run_op(1'b0, 4'd3, 8'h00);
        chk("r3_lat", 32'(lat), 7);
        chk("r3_pre", 32'(n_pre), 2);
        chk("r3_wl_cyc", 32'(n_wl), 3);
        chk("r3_wl_drv", 32'(n_wl_drv), 0);
        chk("r3_sense", 32'(n_sense), 1);
        chk("r3_rdata", 32'(rdata), 32'h00);
        chk("r3_verr", 32'(verr_at_ack), 0);

        // Write/read addr 15
        run_op(1'b1, 4'd15, 8'hA5);
        chk("w15_lat", 32'(lat), 32'(W_LAT));
        chk("w15_wl", 32'(wl_seen), 32'h8000);
        run_op(1'b0, 4'd15, 8'h00);
        chk("r15_rdata", 32'(rdata), 32'hA5);
        chk("r15_lat", 32'(lat), 7);

        // Write must leave rdata alone
        run_op(1'b1, 4'd2, 8'h3C);
        chk("w2_rdata_kept", 32'(rdata), 32'hA5);
        run_op(1'b0, 4'd2, 8'h00);
        chk("r2_rdata", 32'(rdata), 32'h3C);

        // Continuous req: reads of 7 cycles, one IDLE cycle each
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 4'd0;
        acks = 0; idles = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            inv_chk();
            if (ack) acks++;
            if (!busy) idles++;
            addr = (c == 32) ? 4'd15 : 4'(c);
            wdata = 8'(c);
        end
        req = 1'b0;
        chk("cont_acks", 32'(acks), 5);
        chk("cont_idles", 32'(idles), 5);
        @(negedge clk);
        @(negedge clk);
        chk("cont_rdata", 32'(rdata), 32'hA5);
        chk("cont_busy_end", 32'(busy), 0);

        // Reset during WL of a write
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 4'd5; wdata = 8'h77;
        @(posedge clk);
        #1 req = 1'b0; we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wl", 32'(wl), 32'h0020);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wl", 32'(wl), 0);
        chk("abort_drv", 32'(drv_en), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ack", 32'(ack), 0);
        rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("abort_no_ack", 32'(acks), 0);

        // Reset wins over simultaneous req
        rst = 1'b1; req = 1'b1; we = 1'b0; addr = 4'd1;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        chk("rst_vs_req_busy", 32'(busy), 0);
        @(negedge clk);
        chk("rst_vs_req_idle", 32'(busy), 0);
        chk("rst_vs_req_rdata", 32'(rdata), 0);

`ifdef SRAM_WVERIFY_EN
        // Verify mismatch: sense amp stuck at 0xFF
        run_op(1'b0, 4'd15, 8'h00);
        chk("vf_pre_rdata", 32'(rdata), 32'hA5);
        force_ff = 1'b1;
        run_op(1'b1, 4'd6, 8'h0F);
        force_ff = 1'b0;
        chk("vf_lat", 32'(lat), 11);
        chk("vf_verr", 32'(verr_at_ack), 1);
        chk("vf_rdata_kept", 32'(rdata), 32'hA5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_row_ctrl.md
SRAM_ROW_CTRL -- requirements
Module: sram_row_ctrl

Interface
REQ-001 SHALL have parameter AW, default 4, meaning address width (2**AW word lines).
REQ-002 SHALL have parameter DW, default 8, meaning bit-line pairs per row (data width).
REQ-003 SHALL have parameter PRE_CYC, default 2, meaning precharge duration in cycles (legal 1..15).
REQ-004 SHALL have parameter WL_CYC, default 2, meaning word-line pulse duration in cycles (legal 1..15).
REQ-005 SHALL have one clock and a synchronous, active-high reset; no other clock or reset SHALL exist.
REQ-006 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port req  input  1  operation request, sampled only in IDLE.
REQ-009 SHALL have port we  input  1  1=write, 0=read, captured with req.
REQ-010 SHALL have port addr  input  AW  row address, captured with req.
REQ-011 SHALL have port wdata  input  DW  write data, captured with req.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port rdata  output  DW  read result, held until next read completes.
REQ-015 SHALL have port verr  output  1  write-verify mismatch, valid with ack.
REQ-016 SHALL have port wl  output  2**AW  one-hot word lines (cell access switches).
REQ-017 SHALL have port pre  output  1  bit-line precharge-high enable.
REQ-018 SHALL have port drv_en  output  1  bit-line driver enable; 0 = bl/blb released to high-Z.
REQ-019 SHALL have port drv_d  output  DW  value driven on bl (blb = complement, driven externally).
REQ-020 SHALL have port sense_en  output  1  sense-amp enable.
REQ-021 SHALL have port sa_q  input  DW  sense-amp output (resolved bl level).

Function
REQ-022 SHALL implement states IDLE, DRV, PRE, WL, SENSE, REC, DONE.
REQ-023 IDLE with req=1 SHALL capture we/addr/wdata and go to DRV (write) or PRE (read); req=0 stays in IDLE.
REQ-024 Write path SHALL be DRV(1 cycle, drv_en=1, drv_d=wdata) -> WL(WL_CYC cycles, drv_en=1, wl[addr]=1) -> REC(1 cycle, all array controls 0) -> DONE.
REQ-025 Read path SHALL be PRE(PRE_CYC, pre=1) -> WL(WL_CYC, wl[addr]=1, drv_en=0) -> SENSE(1 cycle, sense_en=1, wl[addr]=1; rdata<=sa_q at its end) -> REC -> DONE.
REQ-026 DONE SHALL last 1 cycle with ack=1 and return to IDLE; busy=0 in that following IDLE cycle.
REQ-027 Latency, counted from the accepting edge: write ack in cycle WL_CYC+3 (5 at defaults); read ack in cycle PRE_CYC+WL_CYC+3 (7 at defaults).
REQ-028 req, we, addr, wdata SHALL be ignored while busy=1; no queuing; back-to-back requests SHALL require one IDLE cycle between operations.
REQ-029 Invariants every cycle: at most one wl bit high; pre never high with any wl bit or drv_en; drv_en never high with sense_en.
REQ-030 A single down-counter, reloaded on each state entry, SHALL time PRE and WL; a count of 1 means one cycle in state.
REQ-031 rdata SHALL be unchanged by writes; verr SHALL be 0 on read acks.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE regardless of state, including mid-operation.
REQ-033 After reset: busy=0, ack=0, rdata=0, verr=0, wl=0, pre=0, drv_en=0, drv_d=0, sense_en=0.
REQ-034 An operation aborted by reset SHALL produce no ack; rst has priority over a simultaneous req.

Configuration
REQ-035 Macro SRAM_WVERIFY_EN SHALL, when defined, insert after write REC a read-back PRE -> WL -> SENSE -> REC on the same addr, then DONE with verr = (sa_q sampled in SENSE != captured wdata).
REQ-036 With SRAM_WVERIFY_EN defined, write ack SHALL arrive in cycle 2*WL_CYC+PRE_CYC+5 (11 at defaults), and rdata SHALL NOT be updated by the read-back.
REQ-037 Without SRAM_WVERIFY_EN, verr SHALL be tied 0 and write timing SHALL follow REQ-027.

Verification
REQ-038 Reset then write addr=3, wdata=0x00 -> DRV 1 cycle, wl=0x0008 for 2 cycles, ack in cycle 5, pre stays 0.
REQ-039 Read addr=3 with sa_q model returning 0x00 -> pre 2 cycles, wl=0x0008 with drv_en=0, sense_en 1 cycle, ack in cycle 7, rdata=0x00.
REQ-040 Write addr=15, wdata=0xA5, then read addr=15 -> rdata=0xA5; invariant monitor of REQ-029 never fires.
REQ-041 Assert req continuously with varying addr -> exactly one operation per ack, extra requests while busy ignored, one IDLE cycle between operations.
REQ-042 Assert rst during WL of a write -> next cycle wl=0, drv_en=0, busy=0, no ack.
REQ-043 SRAM_WVERIFY_EN defined, sa_q forced 0xFF, write 0x0F -> ack in cycle 11 with verr=1; rdata unchanged.
